sdram_addr_mapper_pipe: RTL and testbench
=========================================

Name: sdram_addr_mapper_pipe

Overview:
Registered, parametrised successor to the combinational AHB-to-SDRAM address mapper. It splits each AHB byte address into bank, row and column using one of two selectable field orders. It tracks the open row of every bank and classifies each request as row-hit, bank-empty or row-conflict. It sits between the AHB slave front end and the SDRAM command scheduler, with valid/ready handshakes on both sides.

Parameters:
ADDR_WIDTH, 32, AHB address width
DATA_WIDTH, 32, SDRAM data width; byte-offset bits = COL_LSB = $clog2(DATA_WIDTH/8)
SDRAM_BANK_WIDTH, 2, bank address bits; NUM_BANKS = 2**SDRAM_BANK_WIDTH
SDRAM_ROW_WIDTH, 13, row address bits
SDRAM_COL_WIDTH, 9, column address bits
CNT_WIDTH, 16, width of the saturating hit/miss statistics counters

Ports:
hclk_i  in  1  clock
hresetn_i  in  1  asynchronous active-low reset
req_valid_i  in  1  request present
req_ready_o  out  1  request accepted when valid&ready
req_addr_i  in  ADDR_WIDTH  AHB byte address
req_write_i  in  1  write flag, passed through
map_mode_i  in  1  0: {bank,row,col,byte}; 1: {row,bank,col,byte}, bank-interleaved
bank_close_i  in  NUM_BANKS  scheduler precharged bank b; invalidates its open row
precharge_all_i  in  1  invalidates all open rows (refresh / PRECHARGE ALL)
map_valid_o  out  1  mapped result valid
map_ready_i  in  1  downstream accepts result
map_bank_o  out  SDRAM_BANK_WIDTH  bank
map_row_o  out  SDRAM_ROW_WIDTH  row
map_col_o  out  SDRAM_COL_WIDTH  column
map_write_o  out  1  registered req_write_i
map_class_o  out  2  00 EMPTY, 01 HIT, 10 CONFLICT
map_err_o  out  1  address bits above the top mapped field were non-zero
hit_cnt_o  out  CNT_WIDTH  saturating count of HIT results accepted into the stage
miss_cnt_o  out  CNT_WIDTH  saturating count of EMPTY+CONFLICT results

Behaviour:
- Reset (async assert, sync release): all outputs 0, all open-row valid bits 0, counters 0. req_ready_o is 1 after reset.
- Field positions:
  - Mode 0: col = addr[COL_LSB +: C], row = addr[COL_LSB+C +: R], bank = addr[COL_LSB+C+R +: B].
  - Mode 1: col same, bank = addr[COL_LSB+C +: B], row = addr[COL_LSB+C+B +: R].
  - TOP = COL_LSB+C+R+B. map_err_o = |addr[ADDR_WIDTH-1:TOP]; the request is still mapped normally. Byte-offset bits are ignored.
- map_mode_i is sampled with each accepted request.
- Single pipeline stage, latency 1 cycle:
  - req_ready_o = !map_valid_o | map_ready_i (combinational).
  - On acceptance, all map_* outputs load on the next edge and map_valid_o sets.
  - map_valid_o clears when map_ready_i is high and no new request is accepted.
  - Outputs hold stable while map_valid_o=1 and map_ready_i=0.
- Open-row table: per bank, a valid bit plus a row register.
  - Classification uses the table state after this cycle's closes are applied. The effective valid for bank b is valid[b] & !bank_close_i[b] & !precharge_all_i.
  - Effective valid 0 -> EMPTY; valid and row equal -> HIT; valid and row differs -> CONFLICT.
- Table update at the clock edge:
  - Close inputs clear the valid bits first.
  - An accepted request then sets valid[bank]=1 and row[bank]=row, so an open wins over a same-cycle close of the same bank.
  - Back-to-back requests see the previous accepted request's update.
- Counters update on acceptance and saturate at all-ones; they do not wrap.
- A reset during operation drops any in-flight result without handshake and clears the table.

Decomposition:
- Package sdram_map_pkg holds:
  - class encoding localparams MAP_EMPTY/MAP_HIT/MAP_CONFLICT
  - mode encoding MAP_MODE_BRC/MAP_MODE_RBC
  - a function computing COL_LSB from DATA_WIDTH
- One sub-module, sdram_open_row_table: NUM_BANKS valid+row registers, close/open update and the classify lookup.
- The field slicing stays in the top level as a combinational function.

Test Plan:
- Reset, mode 0, addr 0x0000_1234, map_ready_i=1 -> one cycle later: valid, bank 0, row 0x2, col 0x8D, EMPTY, err 0; miss_cnt_o=1.
- Next request 0x0000_1238 -> col 0x8E, HIT; then 0x0000_2000 -> bank 0, row 0x4, col 0, CONFLICT; hit_cnt_o=1, miss_cnt_o=2.
- Mode 1, addr 0x0000_0800 -> bank 1, row 0, col 0, EMPTY. Then addr 0x0400_0000 (mode 0) -> map_err_o=1, bank 0, row 0, col 0.
- Hold map_ready_i=0 for 3 cycles with req_valid_i=1 -> req_ready_o=0, outputs unchanged. On release the pending request is accepted the same cycle, with no loss or duplication.
- bank 0 open at row 2; bank_close_i=4'b0001 in the same cycle as request 0x0000_1234 -> EMPTY, and the next identical request -> HIT.
- precharge_all_i pulse, then requests to banks 0 and 1 -> both EMPTY. Force hit_cnt to all-ones, issue a HIT -> counter stays all-ones.

Source files
------------

// File: rtl/sdram_map_pkg.sv
// rtl/sdram_map_pkg.sv - shared encodings and helpers for the SDRAM address mapper
package sdram_map_pkg;

  localparam logic [1:0] MAP_EMPTY    = 2'b00;
  localparam logic [1:0] MAP_HIT      = 2'b01;
  localparam logic [1:0] MAP_CONFLICT = 2'b10;

  localparam logic MAP_MODE_BRC = 1'b0;
  localparam logic MAP_MODE_RBC = 1'b1;

  function automatic int col_lsb(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/sdram_open_row_table.sv
// rtl/sdram_open_row_table.sv - per-bank open-row tracking and request classification
module sdram_open_row_table
  import sdram_map_pkg::*;
#(
  parameter int BANK_WIDTH = 2,
  parameter int ROW_WIDTH  = 13
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [(2**BANK_WIDTH)-1:0]  close_i,
  input  logic                        precharge_all_i,
  input  logic                        open_i,
  input  logic [BANK_WIDTH-1:0]       bank_i,
  input  logic [ROW_WIDTH-1:0]        row_i,
  output logic [1:0]                  class_o
);

  localparam int NUM_BANKS = 2**BANK_WIDTH;

  logic [NUM_BANKS-1:0] valid_q;
  logic [NUM_BANKS-1:0] valid_eff;
  logic [NUM_BANKS-1:0] open_mask;
  logic [ROW_WIDTH-1:0] row_q [NUM_BANKS];

  // Closes are applied before lookup so a same-cycle precharge is already visible.
  assign valid_eff = valid_q & ~close_i & {NUM_BANKS{~precharge_all_i}};
  assign open_mask = open_i ? (NUM_BANKS'(1) << bank_i) : '0;

  always_comb begin
    class_o = MAP_EMPTY;
    if (valid_eff[bank_i]) begin
      class_o = (row_q[bank_i] == row_i) ? MAP_HIT : MAP_CONFLICT;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        row_q[b] <= '0;
      end
    end else begin
      valid_q <= valid_eff | open_mask;
      if (open_i) begin
        row_q[bank_i] <= row_i;
      end
    end
  end

endmodule

// File: rtl/sdram_addr_mapper_pipe.sv
// rtl/sdram_addr_mapper_pipe.sv - registered AHB-to-SDRAM address mapper with open-row classification
module sdram_addr_mapper_pipe
  import sdram_map_pkg::*;
#(
  parameter int ADDR_WIDTH       = 32,
  parameter int DATA_WIDTH       = 32,
  parameter int SDRAM_BANK_WIDTH = 2,
  parameter int SDRAM_ROW_WIDTH  = 13,
  parameter int SDRAM_COL_WIDTH  = 9,
  parameter int CNT_WIDTH        = 16
) (
  input  logic                              hclk_i,
  input  logic                              hresetn_i,
  input  logic                              req_valid_i,
  output logic                              req_ready_o,
  input  logic [ADDR_WIDTH-1:0]             req_addr_i,
  input  logic                              req_write_i,
  input  logic                              map_mode_i,
  input  logic [(2**SDRAM_BANK_WIDTH)-1:0]  bank_close_i,
  input  logic                              precharge_all_i,
  output logic                              map_valid_o,
  input  logic                              map_ready_i,
  output logic [SDRAM_BANK_WIDTH-1:0]       map_bank_o,
  output logic [SDRAM_ROW_WIDTH-1:0]        map_row_o,
  output logic [SDRAM_COL_WIDTH-1:0]        map_col_o,
  output logic                              map_write_o,
  output logic [1:0]                        map_class_o,
  output logic                              map_err_o,
  output logic [CNT_WIDTH-1:0]              hit_cnt_o,
  output logic [CNT_WIDTH-1:0]              miss_cnt_o
);

  localparam int B       = SDRAM_BANK_WIDTH;
  localparam int R       = SDRAM_ROW_WIDTH;
  localparam int C       = SDRAM_COL_WIDTH;
  localparam int COL_LSB = col_lsb(DATA_WIDTH);
  localparam int TOP     = COL_LSB + C + R + B;
  localparam int FW      = 1 + B + R + C;

  // Packs {err, bank, row, col}; byte-offset bits below COL_LSB are ignored.
  function automatic logic [FW-1:0] slice_fields(input logic [ADDR_WIDTH-1:0] addr,
                                                 input logic mode);
    logic [C-1:0] col;
    logic [R-1:0] row;
    logic [B-1:0] bank;
    logic         err;
    col = addr[COL_LSB +: C];
    if (mode == MAP_MODE_RBC) begin
      bank = addr[COL_LSB+C +: B];
      row  = addr[COL_LSB+C+B +: R];
    end else begin
      row  = addr[COL_LSB+C +: R];
      bank = addr[COL_LSB+C+R +: B];
    end
    err = |(addr >> TOP);
    return {err, bank, row, col};
  endfunction

  logic         f_err;
  logic [B-1:0] f_bank;
  logic [R-1:0] f_row;
  logic [C-1:0] f_col;
  logic [1:0]   f_class;
  logic         accept;

  logic                 valid_q, valid_d;
  logic [B-1:0]         bank_q, bank_d;
  logic [R-1:0]         row_q, row_d;
  logic [C-1:0]         col_q, col_d;
  logic                 write_q, write_d;
  logic [1:0]           class_q, class_d;
  logic                 err_q, err_d;
  logic [CNT_WIDTH-1:0] hit_q, hit_d;
  logic [CNT_WIDTH-1:0] miss_q, miss_d;

  assign {f_err, f_bank, f_row, f_col} = slice_fields(req_addr_i, map_mode_i);
  assign req_ready_o = !valid_q || map_ready_i;
  assign accept      = req_valid_i && req_ready_o;

  sdram_open_row_table #(
    .BANK_WIDTH (B),
    .ROW_WIDTH  (R)
  ) u_table (
    .clk_i           (hclk_i),
    .rst_ni          (hresetn_i),
    .close_i         (bank_close_i),
    .precharge_all_i (precharge_all_i),
    .open_i          (accept),
    .bank_i          (f_bank),
    .row_i           (f_row),
    .class_o         (f_class)
  );

  always_comb begin
    valid_d = valid_q;
    bank_d  = bank_q;
    row_d   = row_q;
    col_d   = col_q;
    write_d = write_q;
    class_d = class_q;
    err_d   = err_q;
    hit_d   = hit_q;
    miss_d  = miss_q;
    if (accept) begin
      valid_d = 1'b1;
      bank_d  = f_bank;
      row_d   = f_row;
      col_d   = f_col;
      write_d = req_write_i;
      class_d = f_class;
      err_d   = f_err;
      if (f_class == MAP_HIT) begin
        if (hit_q != '1) hit_d = hit_q + 1'b1;
      end else if (miss_q != '1) begin
        miss_d = miss_q + 1'b1;
      end
    end else if (map_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge hclk_i or negedge hresetn_i) begin
    if (!hresetn_i) begin
      valid_q <= 1'b0;
      bank_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      write_q <= 1'b0;
      class_q <= MAP_EMPTY;
      err_q   <= 1'b0;
      hit_q   <= '0;
      miss_q  <= '0;
    end else begin
      valid_q <= valid_d;
      bank_q  <= bank_d;
      row_q   <= row_d;
      col_q   <= col_d;
      write_q <= write_d;
      class_q <= class_d;
      err_q   <= err_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
    end
  end

  assign map_valid_o = valid_q;
  assign map_bank_o  = bank_q;
  assign map_row_o   = row_q;
  assign map_col_o   = col_q;
  assign map_write_o = write_q;
  assign map_class_o = class_q;
  assign map_err_o   = err_q;
  assign hit_cnt_o   = hit_q;
  assign miss_cnt_o  = miss_q;

endmodule

// File: tb/tb_sdram_addr_mapper_pipe.sv
// tb/tb_sdram_addr_mapper_pipe.sv - randomized self-checking bench against a behavioural mapper model
module tb_sdram_addr_mapper_pipe;

  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic        clk = 1'b0;
  logic        hresetn;
  logic        req_valid, req_ready, req_write, map_mode, precharge_all;
  logic [31:0] req_addr;
  logic [3:0]  bank_close;
  logic        map_valid, map_ready, map_write, map_err;
  logic [1:0]  map_bank, map_class;
  logic [12:0] map_row;
  logic [8:0]  map_col;
  logic [CW-1:0] hit_cnt, miss_cnt;

  always #5 clk = ~clk;

  sdram_addr_mapper_pipe #(.CNT_WIDTH(CW)) dut (
    .hclk_i(clk), .hresetn_i(hresetn),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_write_i(req_write), .map_mode_i(map_mode), .bank_close_i(bank_close),
    .precharge_all_i(precharge_all), .map_valid_o(map_valid), .map_ready_i(map_ready),
    .map_bank_o(map_bank), .map_row_o(map_row), .map_col_o(map_col),
    .map_write_o(map_write), .map_class_o(map_class), .map_err_o(map_err),
    .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference state: open rows per bank and the expected output register contents.
  bit          m_open [4];
  int unsigned m_row  [4];
  int unsigned e_valid, e_bank, e_row, e_col, e_write, e_class, e_err, e_hit, e_miss;

  task automatic model_reset();
    for (int b = 0; b < 4; b++) begin
      m_open[b] = 0;
      m_row[b]  = 0;
    end
    e_valid = 0; e_bank = 0; e_row = 0; e_col = 0; e_write = 0;
    e_class = 0; e_err = 0; e_hit = 0; e_miss = 0;
  endtask

  task automatic check_outputs();
    chk("valid", map_valid, e_valid);
    chk("bank",  map_bank,  e_bank);
    chk("row",   map_row,   e_row);
    chk("col",   map_col,   e_col);
    chk("write", map_write, e_write);
    chk("class", map_class, e_class);
    chk("err",   map_err,   e_err);
    chk("hit",   hit_cnt,   e_hit);
    chk("miss",  miss_cnt,  e_miss);
  endtask

  task automatic do_cycle(input bit v, input logic [31:0] a, input bit w, input bit m,
                          input logic [3:0] cl, input bit pa, input bit rdy_in);
    bit          rdy, acc;
    int unsigned bk, rw, cls;
    req_valid = v; req_addr = a; req_write = w; map_mode = m;
    bank_close = cl; precharge_all = pa; map_ready = rdy_in;
    #1;
    rdy = (e_valid == 0) || rdy_in;
    chk("ready", req_ready, rdy);
    acc = v && rdy;
    for (int b = 0; b < 4; b++) if (cl[b] || pa) m_open[b] = 0;
    if (acc) begin
      if (m) begin
        bk = (a >> 11) % 4;
        rw = (a >> 13) % 8192;
      end else begin
        rw = (a >> 11) % 8192;
        bk = (a >> 24) % 4;
      end
      cls = !m_open[bk] ? 0 : ((m_row[bk] == rw) ? 1 : 2);
      m_open[bk] = 1;
      m_row[bk]  = rw;
      e_valid = 1; e_bank = bk; e_row = rw; e_col = (a >> 2) % 512;
      e_write = w; e_class = cls; e_err = ((a >> 26) != 0);
      if (cls == 1) begin
        if (e_hit < SAT) e_hit++;
      end else if (e_miss < SAT) begin
        e_miss++;
      end
    end else if (rdy_in) begin
      e_valid = 0;
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  initial begin
    logic [31:0] ra;
    hresetn = 1'b0;
    req_valid = 0; req_addr = '0; req_write = 0; map_mode = 0;
    bank_close = '0; precharge_all = 0; map_ready = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    chk("reset_ready", req_ready, 1);
    hresetn = 1'b1;

    do_cycle(1, 32'h0000_1234, 0, 0, 4'b0000, 0, 1);
    chk("t1_col", map_col, 9'h08D);
    chk("t1_row", map_row, 13'h2);
    chk("t1_class", map_class, 2'b00);
    chk("t1_miss", miss_cnt, 1);
    do_cycle(1, 32'h0000_1238, 1, 0, 4'b0000, 0, 1);
    chk("t2_hit", map_class, 2'b01);
    chk("t2_col", map_col, 9'h08E);
    do_cycle(1, 32'h0000_2000, 0, 0, 4'b0000, 0, 1);
    chk("t3_conflict", map_class, 2'b10);
    chk("t3_row", map_row, 13'h4);
    chk("t3_cnt", {hit_cnt, miss_cnt}, {4'd1, 4'd2});
    do_cycle(1, 32'h0000_0800, 0, 1, 4'b0000, 0, 1);
    chk("t4_bank", map_bank, 2'd1);
    chk("t4_class", map_class, 2'b00);
    do_cycle(1, 32'h0400_0000, 0, 0, 4'b0000, 0, 1);
    chk("t5_err", map_err, 1);

    // Backpressure: pending request must be taken exactly once on release.
    do_cycle(1, 32'h0000_1234, 0, 0, 4'b0000, 0, 1);
    repeat (3) do_cycle(1, 32'h0000_3000, 1, 0, 4'b0000, 0, 0);
    chk("stall_ready", req_ready, 0);
    do_cycle(1, 32'h0000_3000, 1, 0, 4'b0000, 0, 1);
    do_cycle(0, 32'h0, 0, 0, 4'b0000, 0, 1);
    chk("drain_valid", map_valid, 0);

    do_cycle(1, 32'h0000_1234, 0, 0, 4'b0000, 0, 1);
    do_cycle(1, 32'h0000_1234, 0, 0, 4'b0001, 0, 1);
    chk("close_empty", map_class, 2'b00);
    do_cycle(1, 32'h0000_1234, 0, 0, 4'b0000, 0, 1);
    chk("reopen_hit", map_class, 2'b01);

    do_cycle(0, 32'h0, 0, 0, 4'b0000, 1, 1);
    do_cycle(1, 32'h0000_1234, 0, 0, 4'b0000, 0, 1);
    chk("pall_b0", map_class, 2'b00);
    do_cycle(1, 32'h0100_1234, 0, 0, 4'b0000, 0, 1);
    chk("pall_b1", map_class, 2'b00);

    repeat (20) do_cycle(1, 32'h0000_1234, 0, 0, 4'b0000, 0, 1);
    chk("hit_sat", hit_cnt, SAT);

    for (int i = 0; i < 400; i++) begin
      ra = ($urandom_range(0, 3) << 24) | ($urandom_range(0, 3) << 11) | ($urandom & 32'h7FF);
      if ($urandom_range(0, 15) == 0) ra = ra | (32'h1 << $urandom_range(26, 31));
      do_cycle($urandom_range(0, 3) != 0, ra, 1'($urandom), 1'($urandom),
               ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000,
               $urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0);
    end

    // Mid-flight reset drops the result and clears the table.
    do_cycle(1, 32'h0000_1234, 0, 0, 4'b0000, 0, 0);
    #2 hresetn = 1'b0;
    #1;
    chk("async_rst_valid", map_valid, 0);
    model_reset();
    @(posedge clk);
    #1 hresetn = 1'b1;
    check_outputs();
    do_cycle(1, 32'h0000_1234, 0, 0, 4'b0000, 0, 1);
    chk("post_rst_empty", map_class, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
